// File: rtl/traffic_pkg.sv
// Shared types and default timing constants for the traffic phase timer.
//
// Contents:
//   phase_e        - decoded light phase seen from the light FSM outputs
//   timer_state_e  - phase countdown state
//   DEF_*          - default parameter values used by the timer top level
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAIN = 2'd1,
        SIDE = 2'd2,
        WARN = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } timer_state_e;

    localparam int DEF_N_PED          = 4;
    localparam int DEF_CNT_W          = 8;
    localparam int DEF_MAIN_TICKS     = 30;
    localparam int DEF_SIDE_TICKS     = 20;
    localparam int DEF_WARN_TICKS     = 5;
    localparam int DEF_PED_MAIN_TICKS = 5;

endpackage

// File: rtl/ped_request_latch.sv
// Per-crosswalk pedestrian request latch with OR aggregation.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   set       in   N_PED button inputs; a 1 latches that request
//   clear     in   drop all latched requests on this edge
//   pending   out  N_PED latched requests (registered)
//   request   out  OR of pending, registered from the next-state value
//   any_next  out  OR of the next-state value (combinational)
//
// A set and a clear in the same cycle leave the bit set, so a button
// pressed on the very edge the side phase starts is served next time.
module ped_request_latch
    import traffic_pkg::*;
#(
    parameter int N_PED = DEF_N_PED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_PED-1:0] set,
    input  logic             clear,
    output logic [N_PED-1:0] pending,
    output logic             request,
    output logic             any_next
);

    logic [N_PED-1:0] pending_d;

    always_comb begin
        pending_d = (clear ? '0 : pending) | set;
        any_next  = |pending_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            request <= 1'b0;
        end else begin
            pending <= pending_d;
            request <= any_next;
        end
    end

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase timer and pedestrian request aggregator for the traffic-light FSM.
// Decodes the current light phase, counts the phase duration in ticks and
// raises timer_done when it expires; latches pedestrian buttons until the
// side phase serves them.
//
// Ports:
//   clk                 in   system clock
//   rst                 in   asynchronous active-low reset
//   tick                in   one-clk time-base strobe
//   main_green          in   light FSM output
//   side_green          in   light FSM output
//   warning             in   light FSM output (highest decode priority)
//   ped_btn             in   N_PED pedestrian buttons
//   timer_done          out  phase expired (level, registered)
//   pedestrian_request  out  any pedestrian request pending (registered)
//   ped_pending         out  per-crosswalk latched requests
//   remaining           out  ticks left in the current phase
//
// Optional feature macro: TRAFFIC_PED_SHORTEN_EN
//   When defined, a pending pedestrian request caps the main-green countdown
//   at PED_MAIN_TICKS.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int N_PED          = DEF_N_PED,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int MAIN_TICKS     = DEF_MAIN_TICKS,
    parameter int SIDE_TICKS     = DEF_SIDE_TICKS,
    parameter int WARN_TICKS     = DEF_WARN_TICKS,
    parameter int PED_MAIN_TICKS = DEF_PED_MAIN_TICKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             main_green,
    input  logic             side_green,
    input  logic             warning,
    input  logic [N_PED-1:0] ped_btn,
    output logic             timer_done,
    output logic             pedestrian_request,
    output logic [N_PED-1:0] ped_pending,
    output logic [CNT_W-1:0] remaining
);

    phase_e       phase;
    phase_e       prev_phase;
    logic         phase_change;
    timer_state_e state;
    timer_state_e state_d;
    logic [CNT_W-1:0] remaining_d;
    logic         timer_done_d;
    logic [CNT_W-1:0] load_value;
    logic         ped_any_next;

    // Phase decode, warning first.
    always_comb begin
        if (warning)         phase = WARN;
        else if (main_green) phase = MAIN;
        else if (side_green) phase = SIDE;
        else                 phase = IDLE;
    end

    assign phase_change = (phase != prev_phase);

    always_comb begin
        case (phase)
            MAIN:    load_value = CNT_W'(MAIN_TICKS);
            SIDE:    load_value = CNT_W'(SIDE_TICKS);
            WARN:    load_value = CNT_W'(WARN_TICKS);
            default: load_value = '0;
        endcase
    end

    // Requests are served (cleared) on the edge that enters the side phase.
    ped_request_latch #(
        .N_PED (N_PED)
    ) u_ped_latch (
        .clk      (clk),
        .rst      (rst),
        .set      (ped_btn),
        .clear    (phase_change && (phase == SIDE)),
        .pending  (ped_pending),
        .request  (pedestrian_request),
        .any_next (ped_any_next)
    );

`ifndef TRAFFIC_PED_SHORTEN_EN
    // Only consumed by the shortening feature.
    logic unused_ped_shorten;
    assign unused_ped_shorten = ped_any_next ^ (^CNT_W'(PED_MAIN_TICKS));
`endif

    // Next-state: a phase change always reloads and beats any tick.
    always_comb begin
        state_d      = state;
        remaining_d  = remaining;
        timer_done_d = timer_done;
        if (phase_change) begin
            timer_done_d = 1'b0;
            remaining_d  = load_value;
            state_d      = (phase == IDLE) ? S_IDLE : S_RUN;
        end else begin
            case (state)
                S_IDLE: begin
                    remaining_d  = '0;
                    timer_done_d = 1'b0;
                end
                S_RUN: begin
`ifdef TRAFFIC_PED_SHORTEN_EN
                    if ((phase == MAIN) && ped_any_next &&
                        (remaining > CNT_W'(PED_MAIN_TICKS))) begin
                        remaining_d = CNT_W'(PED_MAIN_TICKS);
                    end else
`endif
                    if (tick) begin
                        remaining_d = remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            state_d      = S_DONE;
                            timer_done_d = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    remaining_d  = '0;
                    timer_done_d = 1'b1;
                end
                default: begin
                    state_d      = S_IDLE;
                    remaining_d  = '0;
                    timer_done_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_phase <= IDLE;
            state      <= S_IDLE;
            remaining  <= '0;
            timer_done <= 1'b0;
        end else begin
            prev_phase <= phase;
            state      <= state_d;
            remaining  <= remaining_d;
            timer_done <= timer_done_d;
        end
    end

endmodule

// File: tb/tb_traffic_phase_timer.sv
module tb_traffic_phase_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       main_green = 1'b0;
  logic       side_green = 1'b0;
  logic       warning = 1'b0;
  logic [3:0] ped_btn = 4'b0000;
  logic       timer_done;
  logic       pedestrian_request;
  logic [3:0] ped_pending;
  logic [7:0] remaining;

  int n_checks = 0;
  int n_fail = 0;

  traffic_phase_timer dut (
    .clk                (clk),
    .rst                (rst),
    .tick               (tick),
    .main_green         (main_green),
    .side_green         (side_green),
    .warning            (warning),
    .ped_btn            (ped_btn),
    .timer_done         (timer_done),
    .pedestrian_request (pedestrian_request),
    .ped_pending        (ped_pending),
    .remaining          (remaining)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (timer_done !== 1'b0 || pedestrian_request !== 1'b0 || ped_pending !== 4'b0 || remaining !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: done=%b req=%b pend=%b rem=%0d, want all 0", timer_done, pedestrian_request, ped_pending, remaining);
    end
    step();
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if (timer_done !== 1'b0 || remaining !== 8'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: done=%b rem=%0d, want 0/0", timer_done, remaining);
    end
  endtask

  task automatic test_main_count();
    main_green = 1'b1;
    step();
    n_checks++;
    if (remaining !== 8'd30 || timer_done !== 1'b0) begin
      n_fail++;
      $display("FAIL main_load: rem=%0d done=%b, want 30/0", remaining, timer_done);
    end
    for (int k = 1; k <= 30; k++) begin
      tick_pulse();
      n_checks++;
      if (remaining !== 8'(30 - k) || timer_done !== (k == 30)) begin
        n_fail++;
        $display("FAIL main_count k=%0d: rem=%0d done=%b, want %0d/%b", k, remaining, timer_done, 30 - k, (k == 30));
      end
      step();
      step();
    end
    // Further ticks in S_DONE are ignored.
    for (int k = 0; k < 3; k++) begin
      tick_pulse();
      n_checks++;
      if (remaining !== 8'd0 || timer_done !== 1'b1) begin
        n_fail++;
        $display("FAIL main_done_hold: rem=%0d done=%b, want 0/1", remaining, timer_done);
      end
    end
  endtask

  task automatic test_warn();
    warning = 1'b1;
    step();
    n_checks++;
    if (remaining !== 8'd5 || timer_done !== 1'b0) begin
      n_fail++;
      $display("FAIL warn_load: rem=%0d done=%b, want 5/0", remaining, timer_done);
    end
    for (int k = 1; k <= 5; k++) begin
      tick_pulse();
      n_checks++;
      if (remaining !== 8'(5 - k) || timer_done !== (k == 5)) begin
        n_fail++;
        $display("FAIL warn_count k=%0d: rem=%0d done=%b, want %0d/%b", k, remaining, timer_done, 5 - k, (k == 5));
      end
    end
  endtask

  task automatic test_back_to_back();
    // Phase change with a tick on the same cycle: load wins.
    warning = 1'b0;
    main_green = 1'b0;
    side_green = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    n_checks++;
    if (remaining !== 8'd20 || timer_done !== 1'b0) begin
      n_fail++;
      $display("FAIL load_beats_tick: rem=%0d done=%b, want 20/0", remaining, timer_done);
    end
    tick_pulse();
    n_checks++;
    if (remaining !== 8'd19) begin
      n_fail++;
      $display("FAIL side_count: rem=%0d, want 19", remaining);
    end
    side_green = 1'b0;
    step();
    n_checks++;
    if (remaining !== 8'd0 || timer_done !== 1'b0) begin
      n_fail++;
      $display("FAIL to_idle: rem=%0d done=%b, want 0/0", remaining, timer_done);
    end
    tick_pulse();
    n_checks++;
    if (remaining !== 8'd0 || timer_done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_tick: rem=%0d done=%b, want 0/0", remaining, timer_done);
    end
  endtask

  task automatic test_ped();
    logic [7:0] exp_rem;
`ifdef TRAFFIC_PED_SHORTEN_EN
    exp_rem = 8'd5;
`else
    exp_rem = 8'd30;
`endif
    main_green = 1'b1;
    step();
    ped_btn = 4'b0100;
    step();
    ped_btn = 4'b0000;
    n_checks++;
    if (ped_pending !== 4'b0100 || pedestrian_request !== 1'b1) begin
      n_fail++;
      $display("FAIL ped_latch: pend=%b req=%b, want 0100/1", ped_pending, pedestrian_request);
    end
    n_checks++;
    if (remaining !== exp_rem) begin
      n_fail++;
      $display("FAIL ped_main_rem: rem=%0d, want %0d", remaining, exp_rem);
    end
    step();
    n_checks++;
    if (ped_pending !== 4'b0100 || pedestrian_request !== 1'b1) begin
      n_fail++;
      $display("FAIL ped_hold: pend=%b req=%b, want 0100/1", ped_pending, pedestrian_request);
    end
    main_green = 1'b0;
    side_green = 1'b1;
    step();
    n_checks++;
    if (ped_pending !== 4'b0000 || pedestrian_request !== 1'b0 || remaining !== 8'd20) begin
      n_fail++;
      $display("FAIL ped_clear: pend=%b req=%b rem=%0d, want 0000/0/20", ped_pending, pedestrian_request, remaining);
    end
  endtask

  task automatic test_set_wins();
    side_green = 1'b0;
    main_green = 1'b1;
    step();
    main_green = 1'b0;
    side_green = 1'b1;
    ped_btn = 4'b0001;
    step();
    ped_btn = 4'b0000;
    n_checks++;
    if (ped_pending !== 4'b0001 || pedestrian_request !== 1'b1 || remaining !== 8'd20) begin
      n_fail++;
      $display("FAIL set_wins: pend=%b req=%b rem=%0d, want 0001/1/20", ped_pending, pedestrian_request, remaining);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) tick_pulse();
    ped_btn = 4'b0010;
    step();
    ped_btn = 4'b0000;
    n_checks++;
    if (remaining !== 8'd12 || ped_pending !== 4'b0011) begin
      n_fail++;
      $display("FAIL mid_side_setup: rem=%0d pend=%b, want 12/0011", remaining, ped_pending);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (timer_done !== 1'b0 || pedestrian_request !== 1'b0 || ped_pending !== 4'b0 || remaining !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: done=%b req=%b pend=%b rem=%0d, want all 0", timer_done, pedestrian_request, ped_pending, remaining);
    end
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if (remaining !== 8'd20 || ped_pending !== 4'b0000 || timer_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_after_reset: rem=%0d pend=%b done=%b, want 20/0000/0", remaining, ped_pending, timer_done);
    end
  endtask

`ifdef TRAFFIC_PED_SHORTEN_EN
  task automatic test_shorten();
    side_green = 1'b0;
    main_green = 1'b1;
    step();
    for (int k = 0; k < 5; k++) tick_pulse();
    n_checks++;
    if (remaining !== 8'd25) begin
      n_fail++;
      $display("FAIL shorten_setup: rem=%0d, want 25", remaining);
    end
    ped_btn = 4'b0010;
    tick = 1'b1;
    step();
    ped_btn = 4'b0000;
    tick = 1'b0;
    n_checks++;
    if (remaining !== 8'd5 || ped_pending !== 4'b0010) begin
      n_fail++;
      $display("FAIL shorten_cap: rem=%0d pend=%b, want 5/0010", remaining, ped_pending);
    end
    for (int k = 1; k <= 5; k++) begin
      tick_pulse();
      n_checks++;
      if (remaining !== 8'(5 - k) || timer_done !== (k == 5)) begin
        n_fail++;
        $display("FAIL shorten_count k=%0d: rem=%0d done=%b, want %0d/%b", k, remaining, timer_done, 5 - k, (k == 5));
      end
    end
  endtask
`endif

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation time limit reached, want completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    test_reset();
    test_main_count();
    test_warn();
    test_back_to_back();
    test_ped();
    test_set_wins();
    test_reset_mid();
`ifdef TRAFFIC_PED_SHORTEN_EN
    test_shorten();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
